sprite_motion_ctrl: RTL and testbench
=====================================

// Module: sprite_motion_ctrl
// PURPOSE
//  Per-frame sprite controller that sits directly upstream of the image sprite renderer.
//  - Moves the sprite with a bouncing motion across the screen.
//  - Produces the x/y position and pop (artwork-select) signals that the renderer consumes.
//  - All outputs change only at frame boundaries, so the sprite never tears mid-frame.
//  - A user trigger starts a timed pop sequence: pop art held, then a cooldown.
// PARAMETERS
//  SPRITE_WIDTH     256   sprite width in pixels (matches renderer WIDTH)
//  SPRITE_HEIGHT    256   sprite height in pixels (matches renderer HEIGHT)
//  SCREEN_WIDTH     1280  active video width
//  SCREEN_HEIGHT    720   active video height
//  SPEED_X          2     x step per frame, pixels, 1..15
//  SPEED_Y          1     y step per frame, pixels, 1..15
//  X_INIT           0     reset x position
//  Y_INIT           0     reset y position
//  POP_FRAMES       8     frames pop_out is held high, >=1
//  COOLDOWN_FRAMES  4     frames after pop during which triggers are ignored, >=1
// PORTS
//  pixel_clk_in  in   1   pixel clock; all logic on its rising edge
//  rst_in        in   1   reset, asynchronous, active-high
//  new_frame_in  in   1   1-cycle pulse, first cycle of vertical blanking
//  trigger_in    in   1   asynchronous-to-frame user trigger (level, already synchronised)
//  move_en_in    in   1   1 = motion enabled; 0 = position frozen
//  x_out         out  11  sprite left edge, drives renderer x_in
//  y_out         out  10  sprite top edge, drives renderer y_in
//  pop_out       out  1   1 = pop artwork (ROM lower half), drives renderer pop_in
//  busy_out      out  1   1 while in POP or COOLDOWN
// BEHAVIOUR
//  Reset values (async):
//  - x_out=X_INIT, y_out=Y_INIT, pop_out=0, busy_out=0.
//  - Direction +x/+y, state IDLE, pending=0, frame counter=0.
//  Trigger edge detection:
//  - A rising edge of trigger_in (registered compare) sets pending.
//  - pending clears on the next new_frame_in.
//  - An edge in the same cycle as new_frame_in is consumed by that frame.
//  - Edges during POP/COOLDOWN are discarded; pending is never set in those states.
//  FSM (transitions only on new_frame_in; all outputs registered, valid the cycle after the pulse):
//  - IDLE: if pending -> POP; pop_out<=1; cnt<=POP_FRAMES-1.
//  - POP: motion frozen; if cnt==0 -> COOLDOWN, pop_out<=0, cnt<=COOLDOWN_FRAMES-1; else cnt--.
//  - COOLDOWN: motion resumes; if cnt==0 -> IDLE, else cnt--.
//  - busy_out = (state != IDLE), registered with state.
//  Motion (per axis, on new_frame_in, when move_en_in=1 and state != POP):
//  - Legal range [0, MAX]: MAX_X = SCREEN_WIDTH-SPRITE_WIDTH, MAX_Y = SCREEN_HEIGHT-SPRITE_HEIGHT.
//  - Next position computed in 12-bit signed: p +/- SPEED.
//  - If next > MAX: p<=MAX and direction<=negative.
//  - If next < 0: p<=0 and direction<=positive.
//  - Landing exactly on 0 or MAX does not flip direction; the flip occurs on the following frame's overshoot.
//  - A reversal step is clamped, never skipped.
//  - move_en_in sampled only on new_frame_in.
//  Timing / boundary conditions:
//  - Latency new_frame_in -> outputs = 1 cycle.
//  - Between pulses outputs are constant.
//  - Back-to-back new_frame_in pulses (test use) each advance one frame.
//  - Reset mid-POP returns to IDLE with pop_out=0 immediately (async).
// STRUCTURE
//  Shared package sprite_pkg:
//  - typedef enum logic [1:0] {IDLE, POP, COOLDOWN} sprite_state_t
//  - SCREEN_WIDTH/HEIGHT defaults
//  - position widths: X_W=11, Y_W=10
//  Sub-module sprite_bounce_axis #(W, MAX, SPEED, INIT):
//  - Instantiated twice (x, y).
//  - Holds position + direction.
//  - Ports: clk, rst, step_en, pos_out.
//  Top level holds edge detect, pending flag, FSM, frame counter.
// TESTING
//  - Reset, X_INIT=0, 3 frame pulses, move_en=1 -> x_out 2,4,6; y_out 1,2,3; pop_out=0.
//  - x at 1022 (MAX_X=1024), 2 frames -> x 1024 (dir unchanged), then 1024 clamp+flip, then 1022.
//  - trigger edge mid-frame, then frame pulse -> pop_out=1, busy=1 for exactly 8 frames, x frozen; 4 cooldown frames busy=1 pop=0; then IDLE.
//  - Triggers during POP and COOLDOWN -> ignored; no second pop after returning to IDLE.
//  - trigger edge coincident with new_frame_in -> pop_out=1 one cycle later.
//  - Assert rst_in mid-POP between clock edges -> outputs at reset values before next edge.
//  - move_en=0 over 5 frames -> x/y unchanged; pop sequence still runs normally.

Source files
------------

// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_pkg
//  Purpose  : Shared types and constants for the sprite motion controller.
//  Revision : 1.0  initial release
// ============================================================================
package sprite_pkg;

    // Frame-sequencing states of the pop/cooldown controller
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        POP      = 2'd1,
        COOLDOWN = 2'd2
    } sprite_state_t;

    // Default active video geometry
    localparam int DEFAULT_SCREEN_WIDTH  = 1280;
    localparam int DEFAULT_SCREEN_HEIGHT = 720;

    // Position bus widths consumed by the renderer
    localparam int X_W = 11;
    localparam int Y_W = 10;

endpackage : sprite_pkg
`default_nettype wire

// File: rtl/sprite_bounce_axis.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_bounce_axis
//  Purpose  : One axis of a bouncing sprite: position plus travel direction,
//             clamped to [0, MAX] with a direction flip on overshoot.
//  Revision : 1.0  initial release
// ============================================================================
module sprite_bounce_axis #(
    parameter int W     = 11,
    parameter int MAX   = 1024,
    parameter int SPEED = 2,
    parameter int INIT  = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step_en,
    output logic [W-1:0] pos_out
);

    // The signed working width is 12 bits; W must stay below that so the
    // zero-extended position always reads as non-negative.
    localparam logic signed [11:0] c_max     = 12'(MAX);
    localparam logic signed [11:0] c_speed   = 12'(SPEED);
    localparam logic [W-1:0]       c_max_pos = W'(MAX);
    localparam logic [W-1:0]       c_init    = W'(INIT);

    logic [W-1:0]       pos_q;
    logic [W-1:0]       pos_d;
    logic               dir_neg_q;
    logic               dir_neg_d;
    logic signed [11:0] w_pos_ext;
    logic signed [11:0] w_pos_next;

    assign w_pos_ext = {{(12-W){1'b0}}, pos_q};

    // Candidate step, then clamp; landing exactly on a bound keeps direction
    always_comb begin
        w_pos_next = dir_neg_q ? (w_pos_ext - c_speed) : (w_pos_ext + c_speed);
        pos_d      = pos_q;
        dir_neg_d  = dir_neg_q;
        if (step_en) begin
            if (w_pos_next > c_max) begin
                pos_d     = c_max_pos;
                dir_neg_d = 1'b1;
            end else if (w_pos_next < 12'sd0) begin
                pos_d     = '0;
                dir_neg_d = 1'b0;
            end else begin
                pos_d     = w_pos_next[W-1:0];
            end
        end
    end

    // Position and direction registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q     <= c_init;
            dir_neg_q <= 1'b0;
        end else begin
            pos_q     <= pos_d;
            dir_neg_q <= dir_neg_d;
        end
    end

    assign pos_out = pos_q;

endmodule : sprite_bounce_axis
`default_nettype wire

// File: rtl/sprite_motion_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_motion_ctrl
//  Purpose  : Per-frame sprite controller: bouncing x/y motion plus a
//             trigger-started pop/cooldown sequence. All outputs update only
//             on new_frame_in so the renderer never tears mid-frame.
//  Revision : 1.0  initial release
// ============================================================================
module sprite_motion_ctrl
    import sprite_pkg::*;
#(
    parameter int SPRITE_WIDTH    = 256,
    parameter int SPRITE_HEIGHT   = 256,
    parameter int SCREEN_WIDTH    = DEFAULT_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT   = DEFAULT_SCREEN_HEIGHT,
    parameter int SPEED_X         = 2,
    parameter int SPEED_Y         = 1,
    parameter int X_INIT          = 0,
    parameter int Y_INIT          = 0,
    parameter int POP_FRAMES      = 8,
    parameter int COOLDOWN_FRAMES = 4
) (
    input  logic           pixel_clk_in,
    input  logic           rst_in,
    input  logic           new_frame_in,
    input  logic           trigger_in,
    input  logic           move_en_in,
    output logic [X_W-1:0] x_out,
    output logic [Y_W-1:0] y_out,
    output logic           pop_out,
    output logic           busy_out
);

    localparam int c_max_x   = SCREEN_WIDTH  - SPRITE_WIDTH;
    localparam int c_max_y   = SCREEN_HEIGHT - SPRITE_HEIGHT;
    localparam int c_cnt_max = (POP_FRAMES > COOLDOWN_FRAMES) ? POP_FRAMES : COOLDOWN_FRAMES;
    localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;

    localparam logic [c_cnt_w-1:0] c_pop_last  = c_cnt_w'(POP_FRAMES - 1);
    localparam logic [c_cnt_w-1:0] c_cool_last = c_cnt_w'(COOLDOWN_FRAMES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    sprite_state_t      state_q;
    logic [c_cnt_w-1:0] cnt_q;
    logic               pop_q;
    logic               busy_q;
    logic               trig_prev_q;
    logic               pending_q;
    logic               w_trig_rise;
    logic               w_start_pop;
    logic               w_step_en;

    assign w_trig_rise = trigger_in & ~trig_prev_q;
    // An edge arriving with the frame pulse is honoured by that same frame
    assign w_start_pop = pending_q | w_trig_rise;
    // The frame that enters POP still moves; frames evaluated in POP do not
    assign w_step_en   = new_frame_in & move_en_in & (state_q != POP);

    // Previous trigger level for rising-edge detection
    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            trig_prev_q <= 1'b0;
        end else begin
            trig_prev_q <= trigger_in;
        end
    end

    // Latch a mid-frame trigger edge until the next frame boundary, IDLE only
    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            pending_q <= 1'b0;
        end else if (new_frame_in) begin
            pending_q <= 1'b0;
        end else if (w_trig_rise && (state_q == IDLE)) begin
            pending_q <= 1'b1;
        end
    end

    // Pop/cooldown sequencer with registered pop/busy outputs
    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pop_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else if (new_frame_in) begin
            case (state_q)
                IDLE: begin
                    if (w_start_pop) begin
                        state_q <= POP;
                        cnt_q   <= c_pop_last;
                        pop_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                POP: begin
                    if (cnt_q == '0) begin
                        state_q <= COOLDOWN;
                        cnt_q   <= c_cool_last;
                        pop_q   <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q - c_cnt_one;
                    end
                end
                COOLDOWN: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q - c_cnt_one;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    pop_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    sprite_bounce_axis #(
        .W     (X_W),
        .MAX   (c_max_x),
        .SPEED (SPEED_X),
        .INIT  (X_INIT)
    ) u_axis_x (
        .clk     (pixel_clk_in),
        .rst     (rst_in),
        .step_en (w_step_en),
        .pos_out (x_out)
    );

    sprite_bounce_axis #(
        .W     (Y_W),
        .MAX   (c_max_y),
        .SPEED (SPEED_Y),
        .INIT  (Y_INIT)
    ) u_axis_y (
        .clk     (pixel_clk_in),
        .rst     (rst_in),
        .step_en (w_step_en),
        .pos_out (y_out)
    );

    assign pop_out  = pop_q;
    assign busy_out = busy_q;

endmodule : sprite_motion_ctrl
`default_nettype wire

// File: tb/tb_sprite_motion_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sprite_motion_ctrl
//  Purpose  : Self-checking bench for sprite_motion_ctrl with a frame-level
//             reference model (bounce arithmetic plus a pop-sequence position).
//  Revision : 1.0  initial release
// ============================================================================
module tb_sprite_motion_ctrl;

    localparam int P_POP   = 8;
    localparam int P_COOL  = 4;
    localparam int P_MAX_X = 1280 - 256;
    localparam int P_MAX_Y = 720 - 256;
    localparam int P_SPD_X = 2;
    localparam int P_SPD_Y = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        nf;
    logic        trg;
    logic        men;
    logic [10:0] x;
    logic [9:0]  y;
    logic        pop;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_x, m_y, m_dx, m_dy;
    int m_seq;      // -1 idle, else frames elapsed since the pop started
    bit m_pend;
    bit m_prev;

    int saved_x, saved_y;

    sprite_motion_ctrl dut (
        .pixel_clk_in (clk),
        .rst_in       (rst),
        .new_frame_in (nf),
        .trigger_in   (trg),
        .move_en_in   (men),
        .x_out        (x),
        .y_out        (y),
        .pop_out      (pop),
        .busy_out     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp_v);
        checks++;
        assert (obs === 32'(exp_v)) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_x = 0; m_y = 0; m_dx = 1; m_dy = 1;
        m_seq = -1; m_pend = 1'b0; m_prev = 1'b0;
    endtask

    task automatic move_axis(inout int p, inout int d, input int spd, input int mx);
        int n;
        n = p + d * spd;
        if (n > mx) begin
            p = mx; d = -1;
        end else if (n < 0) begin
            p = 0; d = 1;
        end else begin
            p = n;
        end
    endtask

    // One rising clock edge of the model with the given inputs
    task automatic model_clock(input bit nf_v, input bit trg_v, input bit men_v);
        bit rise, idle, frozen;
        rise   = trg_v && !m_prev;
        m_prev = trg_v;
        if (nf_v) begin
            idle   = (m_seq < 0);
            frozen = (m_seq >= 0) && (m_seq < P_POP);
            if (men_v && !frozen) begin
                move_axis(m_x, m_dx, P_SPD_X, P_MAX_X);
                move_axis(m_y, m_dy, P_SPD_Y, P_MAX_Y);
            end
            if (idle) begin
                if (m_pend || rise) m_seq = 0;
            end else begin
                m_seq++;
                if (m_seq >= P_POP + P_COOL) m_seq = -1;
            end
            m_pend = 1'b0;
        end else if (rise && m_seq < 0) begin
            m_pend = 1'b1;
        end
    endtask

    function automatic int m_pop();
        return (m_seq >= 0 && m_seq < P_POP) ? 1 : 0;
    endfunction

    function automatic int m_busy();
        return (m_seq >= 0) ? 1 : 0;
    endfunction

    task automatic tick(input bit nf_v, input bit trg_v, input bit men_v);
        @(negedge clk);
        nf  = nf_v;
        trg = trg_v;
        men = men_v;
        model_clock(nf_v, trg_v, men_v);
        @(posedge clk);
        #1;
        nf = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".x"},    32'(x),    m_x);
        chk({tag, ".y"},    32'(y),    m_y);
        chk({tag, ".pop"},  32'(pop),  m_pop());
        chk({tag, ".busy"}, 32'(busy), m_busy());
    endtask

    task automatic frame(input bit trg_v, input bit men_v, input string tag);
        tick(1'b1, trg_v, men_v);
        check_all(tag);
    endtask

    initial begin
        // ---- reset ----
        rst = 1'b1; nf = 1'b0; trg = 1'b0; men = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst.x", 32'(x), 0);
        chk("rst.y", 32'(y), 0);
        chk("rst.pop", 32'(pop), 0);
        chk("rst.busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;

        // ---- first three frames ----
        for (int i = 1; i <= 3; i++) begin
            frame(1'b0, 1'b1, "start");
            chk("start.x_abs", 32'(x), 2 * i);
            chk("start.y_abs", 32'(y), i);
            chk("start.pop_abs", 32'(pop), 0);
        end

        // ---- run toward the right edge ----
        repeat (508) frame(1'b0, 1'b1, "run");
        chk("edge.x1022", 32'(x), 1022);
        frame(1'b0, 1'b1, "edge1");
        chk("edge.x1024a", 32'(x), 1024);
        frame(1'b0, 1'b1, "edge2");
        chk("edge.x1024b", 32'(x), 1024);
        frame(1'b0, 1'b1, "edge3");
        chk("edge.x1022b", 32'(x), 1022);

        // ---- mid-frame trigger, then the pop sequence with ignored triggers ----
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        frame(1'b1, 1'b1, "pop0");
        chk("pop0.pop_abs", 32'(pop), 1);
        chk("pop0.busy_abs", 32'(busy), 1);
        saved_x = int'(x);
        for (int i = 1; i < 8; i++) begin
            tick(1'b0, 1'b0, 1'b1);
            tick(1'b0, 1'b1, 1'b1);
            frame(1'b1, 1'b1, "popn");
            chk("popn.pop_abs", 32'(pop), 1);
            chk("popn.frozen", 32'(x), saved_x);
        end
        frame(1'b1, 1'b1, "cool0");
        chk("cool0.pop_abs", 32'(pop), 0);
        chk("cool0.busy_abs", 32'(busy), 1);
        chk("cool0.frozen", 32'(x), saved_x);
        for (int i = 1; i < 4; i++) begin
            tick(1'b0, 1'b0, 1'b1);
            tick(1'b0, 1'b1, 1'b1);
            frame(1'b1, 1'b1, "cooln");
            chk("cooln.busy_abs", 32'(busy), 1);
        end
        frame(1'b1, 1'b1, "idle0");
        chk("idle0.busy_abs", 32'(busy), 0);
        repeat (3) begin
            frame(1'b1, 1'b1, "idle");
            chk("idle.pop_abs", 32'(pop), 0);
        end

        // ---- trigger edge coincident with the frame pulse ----
        tick(1'b0, 1'b0, 1'b1);
        frame(1'b1, 1'b1, "coin");
        chk("coin.pop_abs", 32'(pop), 1);
        repeat (2) frame(1'b1, 1'b1, "coinpop");

        // ---- asynchronous reset in the middle of POP ----
        tick(1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst.pop", 32'(pop), 0);
        chk("arst.busy", 32'(busy), 0);
        chk("arst.x", 32'(x), 0);
        chk("arst.y", 32'(y), 0);
        @(negedge clk);
        rst = 1'b0;

        // ---- motion disabled while a pop sequence runs ----
        repeat (5) frame(1'b0, 1'b1, "pre");
        saved_x = int'(x);
        saved_y = int'(y);
        tick(1'b0, 1'b1, 1'b0);
        frame(1'b1, 1'b0, "hold0");
        chk("hold0.pop_abs", 32'(pop), 1);
        for (int i = 0; i < 13; i++) begin
            frame(1'b1, 1'b0, "hold");
            chk("hold.x", 32'(x), saved_x);
            chk("hold.y", 32'(y), saved_y);
        end
        chk("hold.done", 32'(busy), 0);

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 6000; i++) begin
            bit r_nf, r_trg, r_men;
            r_nf  = ($urandom_range(0, 2) == 0);
            r_trg = ($urandom_range(0, 4) == 0) ? ~trg : trg;
            r_men = ($urandom_range(0, 7) != 0);
            tick(r_nf, r_trg, r_men);
            if (r_nf) check_all("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sprite_motion_ctrl
`default_nettype wire
